// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 raster constants for the VGA frame timer.
// Latency: n/a (declarations only).
// Backpressure: n/a (no handshakes; the raster free-runs every clock).
package vga_timing_pkg;

  typedef logic [9:0]  pos_t;
  typedef logic [15:0] frame_cnt_t;

  // Position counters are 10 bits wide, so neither axis may exceed this many steps.
  localparam int POS_LIMIT = 1024;

  // Default horizontal timing, in pixel clocks.
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;

  // Default vertical timing, in lines.
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Sync windows (inclusive) measured from the start of the line/frame.
  localparam int VGA_HSYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_HSYNC_END   = VGA_HSYNC_START + VGA_H_SYNC - 1;
  localparam int VGA_VSYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_VSYNC_END   = VGA_VSYNC_START + VGA_V_SYNC - 1;

  // Pin level for a sync signal: inverts the window flag when pulses are active-low.
  function automatic logic sync_level(input logic in_sync, input logic active_low);
    return in_sync ^ active_low;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap strobe and active/sync window decode.
// Latency: pos is a flop; wrap/active/in_sync decode the current pos combinationally.
// Backpressure: none; steps once per clock whenever advance is high.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = VGA_H_TOTAL,
  parameter int ACTIVE     = VGA_H_ACTIVE,
  parameter int SYNC_START = VGA_HSYNC_START,
  parameter int SYNC_LEN   = VGA_H_SYNC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  output logic [9:0] pos,
  output logic       wrap,
  output logic       active,
  output logic       in_sync
);

  // Reject geometries that cannot be represented by a 10-bit position.
  if (TOTAL > POS_LIMIT || TOTAL < 2) begin : g_bad_total
    $error("vga_axis_counter: TOTAL=%0d outside 2..%0d", TOTAL, POS_LIMIT);
  end
  if (ACTIVE < 1 || ACTIVE > TOTAL) begin : g_bad_active
    $error("vga_axis_counter: ACTIVE=%0d outside 1..TOTAL", ACTIVE);
  end
  if (SYNC_LEN < 1 || SYNC_START + SYNC_LEN > TOTAL) begin : g_bad_sync
    $error("vga_axis_counter: sync window does not fit inside TOTAL");
  end

  // Inclusive bounds, pre-truncated to position width so every compare is 10-bit.
  localparam pos_t LAST       = pos_t'(TOTAL - 1);
  localparam pos_t ACT_LAST   = pos_t'(ACTIVE - 1);
  localparam pos_t SYNC_FIRST = pos_t'(SYNC_START);
  localparam pos_t SYNC_LAST  = pos_t'(SYNC_START + SYNC_LEN - 1);

  pos_t pos_q;
  pos_t pos_d;

  // Next position: hold, step, or wrap to zero after the last position.
  always_comb begin
    pos_d = pos_q;
    if (advance) begin
      pos_d = (pos_q == LAST) ? '0 : pos_q + 10'd1;
    end
  end

  // Position register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos     = pos_q;
  assign wrap    = advance && (pos_q == LAST);
  assign active  = (pos_q <= ACT_LAST);
  assign in_sync = (pos_q >= SYNC_FIRST) && (pos_q <= SYNC_LAST);

endmodule

// File: rtl/vga_frame_timer.sv
// VGA raster timer: hsync/vsync/display_on/position/strobes plus a per-frame latched control byte.
// Latency: all outputs are flops; the first edge after reset release presents position (0,0).
// Backpressure: none; free-running. Optional macro VGA_FRAME_TIMER_INPUT_EDGE_EN enables ui_rise.
//
// The two axis counters run one position ahead of the outputs: every output register samples
// the counters' current position and its decode, so hpos/vpos and every decoded signal leave
// through the same rank of flops with zero skew and no input reaches an output without a flop.
module vga_frame_timer
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE        = VGA_H_ACTIVE,
  parameter int H_FP            = VGA_H_FP,
  parameter int H_SYNC          = VGA_H_SYNC,
  parameter int H_BP            = VGA_H_BP,
  parameter int V_ACTIVE        = VGA_V_ACTIVE,
  parameter int V_FP            = VGA_V_FP,
  parameter int V_SYNC          = VGA_V_SYNC,
  parameter int V_BP            = VGA_V_BP,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ui_in,
  output logic        hsync,
  output logic        vsync,
  output logic        display_on,
  output logic [9:0]  hpos,
  output logic [9:0]  vpos,
  output logic        line_start,
  output logic        frame_start,
  output logic [7:0]  ui_frame,
  output logic [15:0] frame_count,
  output logic [7:0]  ui_rise
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Both totals must fit the 10-bit position counters.
  if (H_TOTAL > POS_LIMIT) begin : g_bad_h_total
    $error("vga_frame_timer: H_TOTAL=%0d exceeds %0d", H_TOTAL, POS_LIMIT);
  end
  if (V_TOTAL > POS_LIMIT) begin : g_bad_v_total
    $error("vga_frame_timer: V_TOTAL=%0d exceeds %0d", V_TOTAL, POS_LIMIT);
  end

  // Level driven on the sync pins outside their pulse.
  localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW ? 1'b1 : 1'b0;

  // ---------------------------------------------------------------- axis counters
  pos_t h_pos;
  pos_t v_pos;
  logic h_wrap;
  logic v_wrap_unused;
  logic h_active;
  logic v_active;
  logic h_in_sync;
  logic v_in_sync;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_LEN   (H_SYNC)
  ) u_h_axis (
    .clk     (clk),
    .rst     (rst),
    .advance (1'b1),
    .pos     (h_pos),
    .wrap    (h_wrap),
    .active  (h_active),
    .in_sync (h_in_sync)
  );

  // The vertical axis steps once per line, on the edge where the horizontal axis wraps.
  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_LEN   (V_SYNC)
  ) u_v_axis (
    .clk     (clk),
    .rst     (rst),
    .advance (h_wrap),
    .pos     (v_pos),
    .wrap    (v_wrap_unused),
    .active  (v_active),
    .in_sync (v_in_sync)
  );

  // Position the output rank is about to present sits at the start of a line / frame.
  logic at_line;
  logic at_frame;
  assign at_line  = (h_pos == '0);
  assign at_frame = at_line && (v_pos == '0);

  // ---------------------------------------------------------------- raster outputs
  pos_t hpos_q, hpos_d;
  pos_t vpos_q, vpos_d;
  logic display_on_q, display_on_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  // Decode the counters' position into the values the output rank will present.
  always_comb begin
    hpos_d        = h_pos;
    vpos_d        = v_pos;
    display_on_d  = h_active && v_active;
    hsync_d       = sync_level(h_in_sync, SYNC_ACTIVE_LOW);
    vsync_d       = sync_level(v_in_sync, SYNC_ACTIVE_LOW);
    line_start_d  = at_line;
    frame_start_d = at_frame;
  end

  // Output rank for position and decoded timing; reset parks syncs at their idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      hpos_q        <= '0;
      vpos_q        <= '0;
      display_on_q  <= 1'b0;
      hsync_q       <= SYNC_IDLE;
      vsync_q       <= SYNC_IDLE;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      display_on_q  <= display_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  // ---------------------------------------------------------------- per-frame state
  logic [7:0] ui_frame_q, ui_frame_d;
  frame_cnt_t frame_count_q, frame_count_d;
  logic       first_frame_q, first_frame_d;

  // At each frame boundary capture ui_in and advance the frame count; the first
  // frame after reset keeps the count at zero so it numbers frames since reset.
  always_comb begin
    ui_frame_d    = ui_frame_q;
    frame_count_d = frame_count_q;
    first_frame_d = first_frame_q;
    if (at_frame) begin
      ui_frame_d    = ui_in;
      first_frame_d = 1'b0;
      if (!first_frame_q) begin
        frame_count_d = frame_count_q + 16'd1;
      end
    end
  end

  // Frame-stable control byte, frame counter and first-frame marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      ui_frame_q    <= '0;
      frame_count_q <= '0;
      first_frame_q <= 1'b1;
    end else begin
      ui_frame_q    <= ui_frame_d;
      frame_count_q <= frame_count_d;
      first_frame_q <= first_frame_d;
    end
  end

`ifdef VGA_FRAME_TIMER_INPUT_EDGE_EN
  // ui_frame_q still holds the previous frame's byte at the boundary, so it doubles as
  // the reference for edge detection (and is zero for the first frame after reset).
  logic [7:0] ui_rise_q, ui_rise_d;

  // Bits that went 0->1 between the previous frame's byte and the newly latched one.
  always_comb begin
    ui_rise_d = ui_rise_q;
    if (at_frame) begin
      ui_rise_d = ui_in & ~ui_frame_q;
    end
  end

  // Rising-edge mask, held for the whole frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      ui_rise_q <= '0;
    end else begin
      ui_rise_q <= ui_rise_d;
    end
  end

  assign ui_rise = ui_rise_q;
`else
  assign ui_rise = 8'h00;
`endif

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign display_on  = display_on_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign ui_frame    = ui_frame_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_frame_timer.sv
// Bench for vga_frame_timer: a shrunken-geometry instance (full frames) and a default 640x480 instance.
// Stimulus pushes per-edge expectations from an arithmetic model; a monitor pops and compares.
// Run-length checks (periods, sync widths, visible-pixel count) are taken from observed outputs.
module tb_vga_frame_timer;

  // Small geometry so many whole frames fit in a short run.
  localparam int S_HA = 16, S_HFP = 4, S_HS = 6, S_HBP = 4;
  localparam int S_VA = 12, S_VFP = 2, S_VS = 2, S_VBP = 3;

  typedef struct packed {
    logic [9:0]  hpos;
    logic [9:0]  vpos;
    logic        hs;
    logic        vs;
    logic        de;
    logic        ls;
    logic        fs;
    logic [7:0]  uif;
    logic [15:0] fc;
    logic [7:0]  uir;
  } obs_t;

  // Index 0 = small instance, 1 = default instance.
  int P_HA[2]  = '{S_HA, 640};
  int P_HFP[2] = '{S_HFP, 16};
  int P_HS[2]  = '{S_HS, 96};
  int P_HT[2]  = '{S_HA + S_HFP + S_HS + S_HBP, 800};
  int P_VA[2]  = '{S_VA, 480};
  int P_VFP[2] = '{S_VFP, 10};
  int P_VS[2]  = '{S_VS, 2};
  int P_VT[2]  = '{S_VA + S_VFP + S_VS + S_VBP, 525};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] cur = 8'h00;

  logic s_hs, s_vs, s_de, s_ls, s_fs;
  logic [9:0] s_hpos, s_vpos;
  logic [7:0] s_uif, s_uir;
  logic [15:0] s_fc;
  logic d_hs, d_vs, d_de, d_ls, d_fs;
  logic [9:0] d_hpos, d_vpos;
  logic [7:0] d_uif, d_uir;
  logic [15:0] d_fc;

  always #10 clk = ~clk;

  vga_frame_timer #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
    .SYNC_ACTIVE_LOW(1'b1)
  ) dut_s (
    .clk(clk), .rst(rst), .ui_in(ui_in),
    .hsync(s_hs), .vsync(s_vs), .display_on(s_de),
    .hpos(s_hpos), .vpos(s_vpos), .line_start(s_ls), .frame_start(s_fs),
    .ui_frame(s_uif), .frame_count(s_fc), .ui_rise(s_uir)
  );

  vga_frame_timer dut_d (
    .clk(clk), .rst(rst), .ui_in(ui_in),
    .hsync(d_hs), .vsync(d_vs), .display_on(d_de),
    .hpos(d_hpos), .vpos(d_vpos), .line_start(d_ls), .frame_start(d_fs),
    .ui_frame(d_uif), .frame_count(d_fc), .ui_rise(d_uir)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  obs_t q0[$];
  obs_t q1[$];

  // Reference model state: cycles since release (-1 while in reset) and latched bytes.
  int         m_t[2] = '{-1, -1};
  logic [7:0] m_uif[2] = '{8'h00, 8'h00};
  logic [7:0] m_uir[2] = '{8'h00, 8'h00};

  task automatic model_step(input int k, input logic r, input logic [7:0] u, output obs_t e);
    int h, v, ft, hs0, vs0;
    e = '0;
    if (r) begin
      m_t[k] = -1;
      m_uif[k] = 8'h00;
      m_uir[k] = 8'h00;
      e.hs = 1'b1;
      e.vs = 1'b1;
    end else begin
      m_t[k] = m_t[k] + 1;
      ft = P_HT[k] * P_VT[k];
      if (m_t[k] % ft == 0) begin
`ifdef VGA_FRAME_TIMER_INPUT_EDGE_EN
        m_uir[k] = u & ~m_uif[k];
`endif
        m_uif[k] = u;
      end
      h   = m_t[k] % P_HT[k];
      v   = (m_t[k] / P_HT[k]) % P_VT[k];
      hs0 = P_HA[k] + P_HFP[k];
      vs0 = P_VA[k] + P_VFP[k];
      e.hpos = 10'(h);
      e.vpos = 10'(v);
      e.de   = (h < P_HA[k]) && (v < P_VA[k]);
      e.hs   = !((h >= hs0) && (h < hs0 + P_HS[k]));
      e.vs   = !((v >= vs0) && (v < vs0 + P_VS[k]));
      e.ls   = (h == 0);
      e.fs   = (m_t[k] % ft == 0);
      e.uif  = m_uif[k];
      e.uir  = m_uir[k];
      e.fc   = 16'((m_t[k] / ft) % 65536);
    end
  endtask

  task automatic apply(input logic r, input logic [7:0] u);
    obs_t e;
    rst = r;
    ui_in = u;
    model_step(0, r, u, e);
    q0.push_back(e);
    model_step(1, r, u, e);
    q1.push_back(e);
  endtask

  task automatic drive(input logic r, input logic [7:0] u);
    @(negedge clk);
    apply(r, u);
  endtask

  // Free-run with the current ui byte until the small instance will present (v,h).
  task automatic run_until(input int v, input int h);
    int n;
    n = 0;
    do begin
      drive(1'b0, cur);
      n++;
    end while (!(((m_t[0] / P_HT[0]) % P_VT[0] == v) && (m_t[0] % P_HT[0] == h)) && n < 2000);
  endtask

  // ------------------------------------------------------------ monitor / scoreboard
  int last_ls[2] = '{-1, -1};
  int last_fs[2] = '{-1, -1};
  int hrun[2]    = '{0, 0};
  int hstart[2]  = '{0, 0};
  int vrun[2]    = '{0, 0};
  int vst_h[2]   = '{0, 0};
  int vst_v[2]   = '{0, 0};
  int de_cnt[2]  = '{0, 0};
  bit de_ok[2]   = '{1'b0, 1'b0};

  task automatic check_inst(input int k, input obs_t a);
    obs_t e;
    int ft;
    ft = P_HT[k] * P_VT[k];
    checks++;
    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
      errors++;
      $display("FAIL underflow inst%0d cyc=%0d: no expectation queued", k, cyc);
      return;
    end
    if (k == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    if (a !== e) begin
      errors++;
      $display("FAIL outputs inst%0d cyc=%0d got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b uif=%h fc=%0d uir=%h want h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b uif=%h fc=%0d uir=%h",
               k, cyc, a.hpos, a.vpos, a.hs, a.vs, a.de, a.ls, a.fs, a.uif, a.fc, a.uir,
               e.hpos, e.vpos, e.hs, e.vs, e.de, e.ls, e.fs, e.uif, e.fc, e.uir);
    end
    if (rst) begin
      last_ls[k] = -1; last_fs[k] = -1; hrun[k] = 0; vrun[k] = 0; de_ok[k] = 1'b0;
      return;
    end
    if (a.ls) begin
      if (last_ls[k] >= 0) begin
        checks++;
        if (cyc - last_ls[k] != P_HT[k]) begin
          errors++;
          $display("FAIL ls_period inst%0d got %0d want %0d", k, cyc - last_ls[k], P_HT[k]);
        end
      end
      last_ls[k] = cyc;
    end
    if (a.fs) begin
      if (last_fs[k] >= 0) begin
        checks++;
        if (cyc - last_fs[k] != ft) begin
          errors++;
          $display("FAIL fs_period inst%0d got %0d want %0d", k, cyc - last_fs[k], ft);
        end
      end
      last_fs[k] = cyc;
    end
    if (!a.hs) begin
      if (hrun[k] == 0) hstart[k] = int'(a.hpos);
      hrun[k]++;
    end else if (hrun[k] > 0) begin
      checks++;
      if (hrun[k] != P_HS[k] || hstart[k] != P_HA[k] + P_HFP[k]) begin
        errors++;
        $display("FAIL hsync_run inst%0d got len=%0d start=%0d want len=%0d start=%0d",
                 k, hrun[k], hstart[k], P_HS[k], P_HA[k] + P_HFP[k]);
      end
      hrun[k] = 0;
    end
    if (!a.vs) begin
      if (vrun[k] == 0) begin
        vst_h[k] = int'(a.hpos);
        vst_v[k] = int'(a.vpos);
      end
      vrun[k]++;
    end else if (vrun[k] > 0) begin
      checks++;
      if (vrun[k] != P_VS[k] * P_HT[k] || vst_h[k] != 0 || vst_v[k] != P_VA[k] + P_VFP[k]) begin
        errors++;
        $display("FAIL vsync_run inst%0d got len=%0d at (%0d,%0d) want len=%0d at (0,%0d)",
                 k, vrun[k], vst_h[k], vst_v[k], P_VS[k] * P_HT[k], P_VA[k] + P_VFP[k]);
      end
      vrun[k] = 0;
    end
    if (a.fs) begin
      if (de_ok[k]) begin
        checks++;
        if (de_cnt[k] != P_HA[k] * P_VA[k]) begin
          errors++;
          $display("FAIL de_frame inst%0d got %0d want %0d", k, de_cnt[k], P_HA[k] * P_VA[k]);
        end
      end
      de_cnt[k] = 0;
      de_ok[k] = 1'b1;
    end
    if (a.de) de_cnt[k]++;
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      check_inst(0, {s_hpos, s_vpos, s_hs, s_vs, s_de, s_ls, s_fs, s_uif, s_fc, s_uir});
      check_inst(1, {d_hpos, d_vpos, d_hs, d_vs, d_de, d_ls, d_fs, d_uif, d_fc, d_uir});
    end
  end

  // ------------------------------------------------------------ stimulus
  initial begin : stimulus
    int r_at;
    apply(1'b1, 8'h00);
    repeat (9) drive(1'b1, 8'h00);

    // Free run with sparse random control-byte changes at arbitrary positions.
    cur = 8'h5A;
    for (int i = 0; i < 1800; i++) begin
      if ($urandom_range(0, 49) == 0) cur = 8'($urandom);
      drive(1'b0, cur);
    end

    // Change at the vsync falling edge, then again mid-frame of the next frame.
    run_until(S_VA + S_VFP, 0);
    cur = 8'hA5;
    run_until(0, 0);
    run_until(5, 0);
    cur = 8'h3C;
    run_until(0, 0);
    repeat (600) drive(1'b0, cur);

    // One-cycle reset at an arbitrary mid-frame position.
    run_until(9, 7);
    drive(1'b1, cur);
    repeat (1200) drive(1'b0, cur);

    // Control-byte sequence 01, 03, 02 across consecutive frames.
    cur = 8'h01;
    run_until(5, 0);
    cur = 8'h03;
    run_until(5, 0);
    cur = 8'h02;
    run_until(5, 0);
    run_until(5, 0);

    // Random tail with one randomly placed reset.
    r_at = $urandom_range(200, 1200);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) cur = 8'($urandom);
      drive(i == r_at, cur);
    end

    @(posedge clk);
    #2;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending want 0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_frame_timer.md
Name: vga_frame_timer

Overview:
- Generates 640x480@60 VGA raster timing for the top-level pin packer:
  - hsync and vsync
  - display_on
  - hpos and vpos
  - per-line and per-frame strobes
- Latches the ui_in control byte once per frame, so the render pipeline sees a value that is stable for a whole frame.
- The bench drives ui_in at the vsync falling edge; this block guarantees the change takes effect only at the next frame_start.
- Runs at 25.175 MHz nominal pixel rate. Simulation runs it at 50 MHz; frame period is 420,000 cycles either way.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE_LOW, 1, 1 = sync pulses drive 0 while active

Ports:
- clk  in  1  pixel clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- ui_in  in  8  raw control byte from the pads
- hsync  out  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
- vsync  out  1  vertical sync, polarity per SYNC_ACTIVE_LOW
- display_on  out  1  high while the position is inside the visible area
- hpos  out  10  current column, 0..H_TOTAL-1
- vpos  out  10  current line, 0..V_TOTAL-1
- line_start  out  1  one-cycle pulse at hpos==0
- frame_start  out  1  one-cycle pulse at hpos==0 and vpos==0
- ui_frame  out  8  ui_in as latched at the last frame_start
- frame_count  out  16  number of frames since reset
- ui_rise  out  8  per-frame rising edges of ui_frame (see Optional Feature)

Behaviour:
- Reset is synchronous and active-high. All outputs are flops. No combinational path from any input to any output.
- Reset values while rst is high:
  - hpos=0, vpos=0
  - display_on=0, line_start=0, frame_start=0
  - hsync and vsync at their inactive level (1 when SYNC_ACTIVE_LOW=1)
  - ui_frame=0, frame_count=0, ui_rise=0
- First edge with rst low: outputs present position (0,0) with display_on=1, line_start=1, frame_start=1, and ui_frame loaded from ui_in.
- Every subsequent edge advances one position.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525.
- hpos increments each cycle.
  - At H_TOTAL-1 it wraps to 0 and vpos increments.
  - vpos wraps from V_TOTAL-1 to 0 on that same edge.
- All decoded outputs are aligned to the hpos/vpos presented in the same cycle (zero skew between position and decode):
  - display_on = (hpos < H_ACTIVE) and (vpos < V_ACTIVE).
  - hsync is active for hpos in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656, 751].
  - vsync is active for vpos in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. [490, 491], for every hpos on those lines.
- ui_frame loads ui_in, sampled at the edge that raises frame_start. It holds for exactly one frame; ui_in changes mid-frame are invisible until the next frame_start.
- frame_count:
  - Stays 0 on the first frame_start after reset.
  - Increments on each later frame_start, in the same cycle as the pulse.
  - Wraps 16'hFFFF to 0.
- Timing invariants: frame_start period is exactly 420,000 cycles; line_start period is exactly 800 cycles.
- Reset mid-operation: at any position, the next edge with rst high forces the reset values. Release restarts at (0,0) with frame_count=0.
- Arithmetic is unsigned 10-bit; comparisons are against parameter-derived constants. Parameters must satisfy H_TOTAL <= 1024 and V_TOTAL <= 1024; enforce with an elaboration-time check.

Optional Feature:
- Macro: VGA_FRAME_TIMER_INPUT_EDGE_EN.
- Defined:
  - At each frame_start, ui_rise = new ui_frame AND NOT previous ui_frame.
  - ui_rise is held for the frame.
  - ui_rise=0 at reset; the first frame after reset compares against 0.
- Undefined: ui_rise is tied to 8'h00 and no previous-value register exists.

Decomposition:
- Package vga_timing_pkg:
  - typedef pos_t (logic [9:0])
  - typedef frame_cnt_t (logic [15:0])
  - default 640x480 localparams and derived H_TOTAL/V_TOTAL
  - sync-window start/end localparams
- Sub-module vga_axis_counter, instantiated twice (horizontal, vertical):
  - Parameters: TOTAL, ACTIVE, SYNC_START, SYNC_LEN.
  - Inputs: clk, rst, advance.
  - Outputs: pos, wrap, active, in_sync.
  - The vertical instance's advance is driven from the horizontal instance's wrap.

Test Plan:
- Release rst after 10 cycles -> first cycle: hpos=0, vpos=0, display_on=1, frame_start=1, line_start=1, hsync=vsync=1.
- Free-run 3 frames -> consecutive frame_start pulses exactly 420,000 cycles apart; line_start exactly 800 apart; frame_count sequence 0,1,2.
- Scan one line and one frame:
  - hsync=0 for exactly 96 cycles, starting hpos=656.
  - vsync=0 for exactly 1,600 cycles, starting at (hpos=0, vpos=490).
  - display_on high for 307,200 cycles per frame.
- Drive ui_in=8'hA5 at vpos=490, then 8'h3C at vpos=100 of the next frame -> ui_frame stays at the old value until the next frame_start, becomes 8'hA5, and never shows 8'h3C until the following frame_start.
- Assert rst for 1 cycle at vpos=300, hpos=123 -> next cycle matches the reset values; after release, frame_start at (0,0) with frame_count=0.
- With VGA_FRAME_TIMER_INPUT_EDGE_EN defined, ui_frame sequence 8'h01, 8'h03, 8'h02 -> ui_rise sequence 8'h01, 8'h02, 8'h00. With the macro undefined, ui_rise stays 8'h00 throughout.
